// File: rtl/rapcla_err_recover.sv
// rapcla_err_recover: exact-sum checker/recovery stage for the reconfigurable approximate CLA adder.
//  clk, rst                  clock and async active-high reset
//  in_valid/in_ready         operand bundle handshake (a, b, cin, approx_sum, approx_cout, rcon)
//  out_valid/out_ready       result bundle handshake
//  exact_sum, exact_cout     corrected result, rippled one group per clock
//  err_groups, err_flag      per-group and overall mismatch of the approximate result
//  err_dist                  exact minus approximate, clamped at 0
//  unexpected_err            mismatch the approximate adder can never legitimately produce
module rapcla_err_recover #(
  parameter int SIZE = 16,
  parameter int GROUPSIZE = 8,
  parameter int WINDOW = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SIZE-1:0]        a,
  input  logic [SIZE-1:0]        b,
  input  logic                   cin,
  input  logic [SIZE-1:0]        approx_sum,
  input  logic                   approx_cout,
  input  logic [SIZE/GROUPSIZE-1:0] rcon,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SIZE-1:0]        exact_sum,
  output logic                   exact_cout,
  output logic [SIZE/GROUPSIZE-1:0] err_groups,
  output logic                   err_flag,
  output logic [SIZE:0]          err_dist,
  output logic                   unexpected_err
);
  localparam int NGROUP = SIZE / GROUPSIZE;
  localparam int GW = NGROUP > 1 ? $clog2(NGROUP) : 1;

  if (SIZE % GROUPSIZE != 0 || NGROUP < 1 || WINDOW < 1) begin : g_bad_param
    $error("rapcla_err_recover: SIZE must be a positive multiple of GROUPSIZE and WINDOW >= 1");
  end

  typedef enum logic [1:0] {IDLE, SCAN, FINAL, HOLD} state_t;
  state_t state, state_nx;

  logic [SIZE-1:0]   a_r, b_r, approx_sum_r;
  logic              approx_cout_r;
  logic [NGROUP-1:0] rcon_r;
  logic              c;
  logic [GW-1:0]     g;
  logic [GROUPSIZE:0] grp;
  logic [SIZE+1:0]   diff;
  logic              flag;
  logic              last;

  assign in_ready  = state == IDLE;
  assign out_valid = state == HOLD;
  assign last = g == GW'(NGROUP - 1);
  assign grp = {1'b0, a_r[int'(g)*GROUPSIZE +: GROUPSIZE]}
             + {1'b0, b_r[int'(g)*GROUPSIZE +: GROUPSIZE]}
             + {{GROUPSIZE{1'b0}}, c};
  // One extra bit so a borrow marks approx > exact, which lost carries cannot cause.
  assign diff = {1'b0, c, exact_sum} - {1'b0, approx_cout_r, approx_sum_r};
  assign flag = |err_groups | (approx_cout_r != c);

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  state_nx = in_valid ? SCAN : IDLE;
      SCAN:  state_nx = last ? FINAL : SCAN;
      FINAL: state_nx = HOLD;
      HOLD:  state_nx = out_ready ? IDLE : HOLD;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_r            <= '0;
      b_r            <= '0;
      approx_sum_r   <= '0;
      approx_cout_r  <= 1'b0;
      rcon_r         <= '0;
      c              <= 1'b0;
      g              <= '0;
      exact_sum      <= '0;
      exact_cout     <= 1'b0;
      err_groups     <= '0;
      err_flag       <= 1'b0;
      err_dist       <= '0;
      unexpected_err <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) begin
        a_r           <= a;
        b_r           <= b;
        approx_sum_r  <= approx_sum;
        approx_cout_r <= approx_cout;
        rcon_r        <= rcon;
        c             <= cin;
        g             <= '0;
        err_groups    <= '0;
      end
      if (state == SCAN) begin
        exact_sum[int'(g)*GROUPSIZE +: GROUPSIZE] <= grp[GROUPSIZE-1:0];
        err_groups[g] <= grp[GROUPSIZE-1:0] != approx_sum_r[int'(g)*GROUPSIZE +: GROUPSIZE];
        c <= grp[GROUPSIZE];
        g <= g + 1'b1;
      end
      if (state == FINAL) begin
        exact_cout     <= c;
        err_flag       <= flag;
        err_dist       <= diff[SIZE+1] ? '0 : diff[SIZE:0];
        unexpected_err <= diff[SIZE+1] | (flag & ~|rcon_r);
      end
    end
endmodule
